// File: rtl/nv_ram_rws_32x16_fifo_ctrl_pkg.sv
// Shared sizing constants and types for the 32x16 RAM-backed FIFO controller.
package nv_ram_fifo_pkg;

   localparam int DEPTH = 32;
   localparam int AW    = 5;
   localparam int DW    = 16;
   localparam int CW    = AW + 1;

   typedef logic [AW-1:0] addr_t;
   typedef logic [DW-1:0] data_t;
   typedef logic [CW-1:0] cnt_t;

endpackage

// File: rtl/nv_ram_rws_32x16_fifo_ctrl_if.sv
// Valid/ready write and read channels between pipeline logic and the FIFO.
interface nv_ram_rws_32x16_fifo_ctrl_if;
   import nv_ram_fifo_pkg::*;

   logic  wr_pvld;
   logic  wr_prdy;
   data_t wr_pd;
   logic  rd_pvld;
   logic  rd_prdy;
   data_t rd_pd;

   // FIFO side
   modport slave (
      input  wr_pvld, wr_pd, rd_prdy,
      output wr_prdy, rd_pvld, rd_pd
   );

   // Producer/consumer side
   modport master (
      output wr_pvld, wr_pd, rd_prdy,
      input  wr_prdy, rd_pvld, rd_pd
   );

endinterface

// File: rtl/nv_ram_rws_32x16_fifo_ctrl_rd_stage.sv
// Read pipeline: RAM read issue, in-flight tracking and the output register.
// The RAM's latched read address acts as the first pipeline slot, so a new
// read is only issued when that slot is empty or drains into the output
// register on the same edge.
module nv_ram_fifo_rd_stage
   import nv_ram_fifo_pkg::*;
(
   input  logic  clk,
   input  logic  rst,
   input  logic  ram_avail,
   input  logic  rd_prdy,
   input  data_t ram_dout,
   output logic  issue,
   output logic  pop,
   output logic  rd_pvld,
   output data_t rd_pd
);

   logic  inflight_q, inflight_d;
   logic  out_vld_q,  out_vld_d;
   data_t rd_pd_q,    rd_pd_d;
   logic  capture;

   // Capture/issue decisions and next state of the read pipeline
   always_comb begin
      pop        = out_vld_q & rd_prdy;
      capture    = inflight_q & (~out_vld_q | pop);
      issue      = ~rst & ram_avail & (~inflight_q | capture);
      inflight_d = inflight_q;
      out_vld_d  = out_vld_q;
      rd_pd_d    = rd_pd_q;
      if (issue) begin
         inflight_d = 1'b1;
      end else if (capture) begin
         inflight_d = 1'b0;
      end
      if (capture) begin
         out_vld_d = 1'b1;
         rd_pd_d   = ram_dout;
      end else if (pop) begin
         out_vld_d = 1'b0;
      end
   end

   // Read pipeline state registers
   always_ff @(posedge clk) begin
      if (rst) begin
         inflight_q <= 1'b0;
         out_vld_q  <= 1'b0;
         rd_pd_q    <= '0;
      end else begin
         inflight_q <= inflight_d;
         out_vld_q  <= out_vld_d;
         rd_pd_q    <= rd_pd_d;
      end
   end

   assign rd_pvld = out_vld_q;
   assign rd_pd   = rd_pd_q;

endmodule

// File: rtl/nv_ram_rws_32x16_fifo_ctrl.sv
// 32x16 FIFO controller driving an external 1R1W RAM with a registered read
// address. Write side and occupancy tracking live here; the read pipeline is
// in nv_ram_fifo_rd_stage.
module nv_ram_rws_32x16_fifo_ctrl
   import nv_ram_fifo_pkg::*;
(
   input  logic        nvdla_core_clk,
   input  logic        nvdla_core_rst,
   nv_ram_rws_32x16_fifo_ctrl_if.slave fifo_if,
   output addr_t       ram_wa,
   output logic        ram_we,
   output data_t       ram_di,
   output addr_t       ram_ra,
   output logic        ram_re,
   input  data_t       ram_dout,
   output cnt_t        fifo_count,
   input  logic [31:0] pwrbus_ram_pd,
   output logic [31:0] pwrbus_ram_pd_o
);

   addr_t wr_ptr_q,  wr_ptr_d;
   addr_t rd_ptr_q,  rd_ptr_d;
   cnt_t  count_q,   count_d;
   cnt_t  ram_cnt_q, ram_cnt_d;
   logic  wr_prdy;
   logic  push;
   logic  pop;
   logic  issue;
   logic  rd_pvld;
   data_t rd_pd;

   // Write acceptance, pointer advance and occupancy bookkeeping.
   // ram_cnt tracks entries written but not yet issued as RAM reads.
   always_comb begin
      wr_prdy   = ~nvdla_core_rst & (count_q < cnt_t'(DEPTH));
      push      = fifo_if.wr_pvld & wr_prdy;
      wr_ptr_d  = push  ? wr_ptr_q + addr_t'(1) : wr_ptr_q;
      rd_ptr_d  = issue ? rd_ptr_q + addr_t'(1) : rd_ptr_q;
      count_d   = count_q + cnt_t'(push) - cnt_t'(pop);
      ram_cnt_d = ram_cnt_q + cnt_t'(push) - cnt_t'(issue);
   end

   // Pointer and counter registers
   always_ff @(posedge nvdla_core_clk) begin
      if (nvdla_core_rst) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         ram_cnt_q <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         ram_cnt_q <= ram_cnt_d;
      end
   end

   nv_ram_fifo_rd_stage u_rd_stage (
      .clk       (nvdla_core_clk),
      .rst       (nvdla_core_rst),
      .ram_avail (ram_cnt_q != '0),
      .rd_prdy   (fifo_if.rd_prdy),
      .ram_dout  (ram_dout),
      .issue     (issue),
      .pop       (pop),
      .rd_pvld   (rd_pvld),
      .rd_pd     (rd_pd)
   );

   assign fifo_if.wr_prdy = wr_prdy;
   assign fifo_if.rd_pvld = rd_pvld;
   assign fifo_if.rd_pd   = rd_pd;

   assign ram_we = push;
   assign ram_wa = wr_ptr_q;
   assign ram_di = fifo_if.wr_pd;
   assign ram_re = issue;
   assign ram_ra = rd_ptr_q;

   assign fifo_count      = count_q;
   assign pwrbus_ram_pd_o = pwrbus_ram_pd;

endmodule
